// File: rtl/mem_slot_arbiter.sv
// Bus-phase / slot scheduler arbitrating shared RAM between fixed-priority device
// fetchers and the CPU; produces the CPU acknowledge and a per-slot cycle_ready strobe.
module mem_slot_arbiter #(
    parameter int                PHASE_BITS   = 3,
    parameter int                SLOTS        = 2,
    parameter logic [SLOTS-1:0]  DEV_SLOT_MAP = 2'b01,
    parameter int                NUM_DEV      = 3,
    parameter int                LATCH_PHASE  = 2,
    parameter int                DONE_PHASE   = 4,
    parameter int                ALLOW_BORROW = 1,
    localparam int               SLOT_W       = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  cpu_req,
    input  logic [NUM_DEV-1:0]    dev_req,
    output logic [PHASE_BITS-1:0] phase,
    output logic [SLOT_W-1:0]     slot,
    output logic                  dev_slot,
    output logic [NUM_DEV-1:0]    dev_grant,
    output logic                  cpu_grant,
    output logic                  cpu_ack,
    output logic                  cycle_ready
);

    localparam logic [PHASE_BITS-1:0] PH_LAST     = '1;
    localparam logic [PHASE_BITS-1:0] PH_PRE_LAST = PHASE_BITS'((2 ** PHASE_BITS) - 2);
    // Phase value whose enabled edge enters LATCH_PHASE (wraps for LATCH_PHASE == 0).
    localparam logic [PHASE_BITS-1:0] PH_LATCH_IN = PHASE_BITS'(LATCH_PHASE - 1 + (2 ** PHASE_BITS));
    localparam logic [PHASE_BITS-1:0] PH_DONE     = PHASE_BITS'(DONE_PHASE);
    localparam logic [SLOT_W-1:0]     SLOT_LAST   = SLOT_W'(SLOTS - 1);

    logic [PHASE_BITS-1:0] phase_q, phase_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [NUM_DEV-1:0]    dev_grant_q, dev_grant_d;
    logic                  cpu_latch_q, cpu_latch_d;
    logic                  cpu_grant_q, cpu_grant_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  served_q, served_d;
    logic                  cycle_ready_q, cycle_ready_d;

    logic wrap;
    logic latch_en;
    logic next_dev_slot;

    always_comb begin
        phase_d       = phase_q;
        slot_d        = slot_q;
        dev_grant_d   = dev_grant_q;
        cpu_latch_d   = cpu_latch_q;
        cpu_grant_d   = cpu_grant_q;
        served_d      = served_q;
        wrap          = clk_en && (phase_q == PH_LAST);
        latch_en      = clk_en && (phase_q == PH_LATCH_IN);

        if (clk_en) begin
            phase_d = phase_q + 1'b1;
            if (phase_q == PH_LAST) begin
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            end
        end
        next_dev_slot = DEV_SLOT_MAP[slot_d];

        // Entering phase 0: highest-priority (lowest-index) device wins the slot.
        if (wrap) begin
            dev_grant_d = next_dev_slot ? (dev_req & (~dev_req + NUM_DEV'(1))) : '0;
            cpu_grant_d = 1'b0;
            cpu_latch_d = 1'b0;
        end

        if (latch_en) begin
            cpu_latch_d = cpu_req;
            cpu_grant_d = cpu_req && !served_q &&
                          (!next_dev_slot || ((ALLOW_BORROW != 0) && (dev_grant_d == '0)));
        end

        // One acknowledged bus cycle per CPU request: block re-grant until cpu_req is seen low.
        if (clk_en && !cpu_req) begin
            served_d = 1'b0;
        end else if (cpu_ack_q) begin
            served_d = 1'b1;
        end

        cpu_ack_d     = cpu_req && cpu_grant_q && cpu_latch_q && (phase_q >= PH_DONE) && !wrap;
        cycle_ready_d = clk_en && (phase_q == PH_PRE_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= '0;
            slot_q        <= '0;
            dev_grant_q   <= '0;
            cpu_latch_q   <= 1'b0;
            cpu_grant_q   <= 1'b0;
            cpu_ack_q     <= 1'b0;
            served_q      <= 1'b0;
            cycle_ready_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            slot_q        <= slot_d;
            dev_grant_q   <= dev_grant_d;
            cpu_latch_q   <= cpu_latch_d;
            cpu_grant_q   <= cpu_grant_d;
            cpu_ack_q     <= cpu_ack_d;
            served_q      <= served_d;
            cycle_ready_q <= cycle_ready_d;
        end
    end

    assign phase       = phase_q;
    assign slot        = slot_q;
    assign dev_slot    = DEV_SLOT_MAP[slot_q];
    assign dev_grant   = dev_grant_q;
    assign cpu_grant   = cpu_grant_q;
    assign cpu_ack     = cpu_ack_q;
    assign cycle_ready = cycle_ready_q;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench: three arbiter configurations (default, no borrowing, 4 slots) on shared stimulus.
module tb_mem_slot_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_en = 1'b0;
    logic       cpu_req = 1'b0;
    logic [2:0] dev_req = 3'b000;

    logic [2:0] ph_a, ph_b, ph_c;
    logic       sl_a, sl_b;
    logic [1:0] sl_c;
    logic       ds_a, ds_b, ds_c;
    logic [2:0] dg_a, dg_b, dg_c;
    logic       cg_a, cg_b, cg_c;
    logic       ca_a, ca_b, ca_c;
    logic       cr_a, cr_b, cr_c;

    int errors = 0;
    int checks = 0;
    int nstep  = 0;
    int sub    = 0;
    int cr_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (cr_a) cr_cnt++;

    mem_slot_arbiter dut_a (
        .clk(clk), .reset(reset), .clk_en(clk_en), .cpu_req(cpu_req), .dev_req(dev_req),
        .phase(ph_a), .slot(sl_a), .dev_slot(ds_a), .dev_grant(dg_a),
        .cpu_grant(cg_a), .cpu_ack(ca_a), .cycle_ready(cr_a)
    );

    mem_slot_arbiter #(.ALLOW_BORROW(0)) dut_b (
        .clk(clk), .reset(reset), .clk_en(clk_en), .cpu_req(cpu_req), .dev_req(dev_req),
        .phase(ph_b), .slot(sl_b), .dev_slot(ds_b), .dev_grant(dg_b),
        .cpu_grant(cg_b), .cpu_ack(ca_b), .cycle_ready(cr_b)
    );

    mem_slot_arbiter #(.SLOTS(4), .DEV_SLOT_MAP(4'b0101)) dut_c (
        .clk(clk), .reset(reset), .clk_en(clk_en), .cpu_req(cpu_req), .dev_req(dev_req),
        .phase(ph_c), .slot(sl_c), .dev_slot(ds_c), .dev_grant(dg_c),
        .cpu_grant(cg_c), .cpu_ack(ca_c), .cycle_ready(cr_c)
    );

    task tick_idle;
        clk_en = 1'b0;
        @(posedge clk);
        #1;
        sub++;
    endtask

    // clk_en high on every 4th clk; returns just after the edge that advanced the phase.
    task phase_step;
        while (sub < 3) tick_idle();
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        sub = 0;
        nstep++;
    endtask

    task goto_step(input int target);
        while (nstep < target) phase_step();
    endtask

    task do_reset;
        cpu_req = 1'b0;
        dev_req = 3'b000;
        clk_en  = 1'b0;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        nstep = 0;
        sub   = 0;
    endtask

    task test_reset;
        do_reset();
        checks++;
        if ({ph_a, sl_a, dg_a, cg_a, ca_a, cr_a} !== 10'd0) begin
            errors++; $display("FAIL reset_a: got %0h want 0", {ph_a, sl_a, dg_a, cg_a, ca_a, cr_a});
        end
        checks++;
        if ({ph_b, sl_b, dg_b, cg_b, ca_b, cr_b} !== 10'd0) begin
            errors++; $display("FAIL reset_b: got %0h want 0", {ph_b, sl_b, dg_b, cg_b, ca_b, cr_b});
        end
        checks++;
        if ({ph_c, sl_c, dg_c, cg_c, ca_c, cr_c} !== 11'd0) begin
            errors++; $display("FAIL reset_c: got %0h want 0", {ph_c, sl_c, dg_c, cg_c, ca_c, cr_c});
        end
        checks++;
        if (ds_a !== 1'b1) begin
            errors++; $display("FAIL reset_devslot: got %0b want 1", ds_a);
        end
    endtask

    task test_counters;
        do_reset();
        cr_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            phase_step();
            checks++;
            if ({ph_a, sl_a} !== {3'(nstep % 8), 1'(nstep / 8)}) begin
                errors++; $display("FAIL cnt_phase_slot step %0d: got %0h want %0h", nstep, {ph_a, sl_a},
                                   {3'(nstep % 8), 1'(nstep / 8)});
            end
            checks++;
            if ({dg_a, cg_a, ca_a, ds_a} !== {5'd0, (nstep / 8) % 2 == 0}) begin
                errors++; $display("FAIL cnt_idle_grants step %0d: got %0h want %0h", nstep,
                                   {dg_a, cg_a, ca_a, ds_a}, {5'd0, (nstep / 8) % 2 == 0});
            end
            checks++;
            if ({sl_c, ds_c} !== {2'(nstep / 8), ((nstep / 8) % 2) == 0}) begin
                errors++; $display("FAIL cnt_slot4 step %0d: got %0h want %0h", nstep, {sl_c, ds_c},
                                   {2'(nstep / 8), ((nstep / 8) % 2) == 0});
            end
            if (nstep == 7) begin
                checks++;
                if (cr_a !== 1'b1) begin
                    errors++; $display("FAIL cycle_ready_on: got %0b want 1", cr_a);
                end
                tick_idle();
                checks++;
                if (cr_a !== 1'b0) begin
                    errors++; $display("FAIL cycle_ready_pulse: got %0b want 0", cr_a);
                end
            end
        end
        checks++;
        if (cr_cnt !== 2) begin
            errors++; $display("FAIL cycle_ready_count: got %0d want 2", cr_cnt);
        end
    endtask

    task test_cpu_slot;
        do_reset();
        goto_step(9);
        cpu_req = 1'b1;
        phase_step();
        checks++;
        if ({cg_a, cg_b, cg_c} !== 3'b111) begin
            errors++; $display("FAIL cpu_grant_p2: got %b want 111", {cg_a, cg_b, cg_c});
        end
        goto_step(12);
        checks++;
        if (ca_a !== 1'b0) begin
            errors++; $display("FAIL cpu_ack_early: got %0b want 0", ca_a);
        end
        tick_idle();
        checks++;
        if ({ca_a, ca_b} !== 2'b11) begin
            errors++; $display("FAIL cpu_ack_p4: got %b want 11", {ca_a, ca_b});
        end
        cpu_req = 1'b0;
        tick_idle();
        checks++;
        if ({ca_a, cg_a} !== 2'b01) begin
            errors++; $display("FAIL cpu_drop: ack,grant got %b want 01", {ca_a, cg_a});
        end
        goto_step(16);
        checks++;
        if ({cg_a, ca_a, ph_a, sl_a} !== 6'b000000) begin
            errors++; $display("FAIL cpu_slot_end: got %b want 000000", {cg_a, ca_a, ph_a, sl_a});
        end
    endtask

    task test_dev_priority;
        do_reset();
        goto_step(15);
        dev_req = 3'b110;
        cpu_req = 1'b1;
        phase_step();
        checks++;
        if ({dg_a, dg_b, dg_c} !== 9'b010_010_010) begin
            errors++; $display("FAIL dev_prio: got %b want 010010010", {dg_a, dg_b, dg_c});
        end
        dev_req = 3'b001;
        goto_step(18);
        checks++;
        if ({cg_a, cg_b, cg_c} !== 3'b000) begin
            errors++; $display("FAIL dev_slot_cpu_blocked: got %b want 000", {cg_a, cg_b, cg_c});
        end
        goto_step(23);
        checks++;
        if (dg_a !== 3'b010) begin
            errors++; $display("FAIL dev_grant_hold: got %b want 010", dg_a);
        end
        goto_step(24);
        checks++;
        if ({dg_a, sl_a, ds_a} !== 5'b00010) begin
            errors++; $display("FAIL dev_cpu_slot: got %b want 00010", {dg_a, sl_a, ds_a});
        end
        goto_step(26);
        checks++;
        if (cg_a !== 1'b1) begin
            errors++; $display("FAIL dev_cpu_next_slot: got %0b want 1", cg_a);
        end
        goto_step(28);
        tick_idle();
        checks++;
        if (ca_a !== 1'b1) begin
            errors++; $display("FAIL dev_cpu_ack: got %0b want 1", ca_a);
        end
        cpu_req = 1'b0;
        dev_req = 3'b000;
    endtask

    task test_borrow;
        do_reset();
        goto_step(15);
        cpu_req = 1'b1;
        goto_step(18);
        checks++;
        if ({cg_a, cg_b, dg_a} !== 5'b10000) begin
            errors++; $display("FAIL borrow_grant: got %b want 10000", {cg_a, cg_b, dg_a});
        end
        goto_step(20);
        tick_idle();
        checks++;
        if ({ca_a, ca_b} !== 2'b10) begin
            errors++; $display("FAIL borrow_ack: got %b want 10", {ca_a, ca_b});
        end
        goto_step(24);
        checks++;
        if ({ca_a, cg_a} !== 2'b00) begin
            errors++; $display("FAIL borrow_slot_end: got %b want 00", {ca_a, cg_a});
        end
        goto_step(26);
        checks++;
        if ({cg_a, cg_b} !== 2'b01) begin
            errors++; $display("FAIL one_access_per_req: got %b want 01", {cg_a, cg_b});
        end
        goto_step(28);
        tick_idle();
        checks++;
        if ({ca_a, ca_b} !== 2'b01) begin
            errors++; $display("FAIL noborrow_ack: got %b want 01", {ca_a, ca_b});
        end
        cpu_req = 1'b0;
    endtask

    task test_late_req;
        do_reset();
        goto_step(11);
        cpu_req = 1'b1;
        goto_step(12);
        tick_idle();
        checks++;
        if ({cg_a, ca_a, cg_b, ca_b} !== 4'b0000) begin
            errors++; $display("FAIL late_no_grant: got %b want 0000", {cg_a, ca_a, cg_b, ca_b});
        end
        goto_step(18);
        checks++;
        if ({cg_a, cg_b} !== 2'b10) begin
            errors++; $display("FAIL late_borrow: got %b want 10", {cg_a, cg_b});
        end
        goto_step(26);
        checks++;
        if (cg_b !== 1'b1) begin
            errors++; $display("FAIL late_next_cpu_slot: got %0b want 1", cg_b);
        end
        cpu_req = 1'b0;
    endtask

    task test_reset_mid;
        do_reset();
        goto_step(15);
        cpu_req = 1'b1;
        goto_step(21);
        tick_idle();
        checks++;
        if ({ph_a, ca_a} !== 4'b1011) begin
            errors++; $display("FAIL rstmid_pre: got %b want 1011", {ph_a, ca_a});
        end
        reset = 1'b1;
        tick_idle();
        checks++;
        if ({ph_a, sl_a, dg_a, cg_a, ca_a, cr_a} !== 10'd0) begin
            errors++; $display("FAIL rstmid_a: got %0h want 0", {ph_a, sl_a, dg_a, cg_a, ca_a, cr_a});
        end
        checks++;
        if ({ph_c, sl_c, cg_c, ca_c} !== 7'd0) begin
            errors++; $display("FAIL rstmid_c: got %0h want 0", {ph_c, sl_c, cg_c, ca_c});
        end
        cpu_req = 1'b0;
        reset   = 1'b0;
        nstep   = 0;
        sub     = 0;
        goto_step(8);
        checks++;
        if ({ca_a, cg_a} !== 2'b00) begin
            errors++; $display("FAIL rstmid_no_ack: got %b want 00", {ca_a, cg_a});
        end
    endtask

    task test_slots4;
        do_reset();
        dev_req = 3'b100;
        goto_step(8);
        checks++;
        if ({sl_c, ds_c, dg_c, dg_a} !== 9'b01_0_000_000) begin
            errors++; $display("FAIL s4_slot1: got %b want 010000000", {sl_c, ds_c, dg_c, dg_a});
        end
        goto_step(16);
        checks++;
        if ({sl_c, ds_c, dg_c, dg_a} !== 9'b10_1_100_100) begin
            errors++; $display("FAIL s4_slot2: got %b want 101100100", {sl_c, ds_c, dg_c, dg_a});
        end
        goto_step(24);
        checks++;
        if ({sl_c, ds_c, dg_c} !== 6'b11_0_000) begin
            errors++; $display("FAIL s4_slot3: got %b want 110000", {sl_c, ds_c, dg_c});
        end
        goto_step(32);
        checks++;
        if ({sl_c, ds_c, dg_c} !== 6'b00_1_100) begin
            errors++; $display("FAIL s4_slot0: got %b want 001100", {sl_c, ds_c, dg_c});
        end
        dev_req = 3'b000;
    endtask

    initial begin
        test_reset();
        test_counters();
        test_cpu_slot();
        test_dev_priority();
        test_borrow();
        test_late_req();
        test_reset_mid();
        test_slots4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_slot_arbiter.md
Name: mem_slot_arbiter

Overview:
- Parametrised successor to the fixed 8-phase CPU/video bus-phase scheme used by the Mac core.
- Generates a free-running bus phase and a programmable slot map, and arbitrates shared RAM among NUM_DEV fixed-priority device fetchers (video, sound, refresh, ...) and the 68k.
- Produces the CPU memory acknowledge (DTACK source) and a cycle_ready strobe for the RAM state machine.
- Sits between the CPU/address decode and the SDRAM controller.

Parameters:
- PHASE_BITS, 3, phase counter width; a slot lasts 2^PHASE_BITS enabled cycles.
- SLOTS, 2, number of slots in the repeating schedule (1..8).
- DEV_SLOT_MAP, 2'b01, bit i=1: slot i is a device slot; bit i=0: slot i is a CPU slot.
- NUM_DEV, 3, number of device requesters; index 0 has the highest priority.
- LATCH_PHASE, 2, phase at which the CPU request is sampled for the current slot.
- DONE_PHASE, 4, first phase at which cpu_ack may assert (memory data valid).
- ALLOW_BORROW, 1, 1 = CPU may use a device slot that no device claimed.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_en  in  1  8 MHz phase enable; all state advances only when high
- cpu_req  in  1  CPU memory request (active-high: /AS low and RAM or ROM selected)
- dev_req  in  NUM_DEV  device fetch requests, sampled at phase 0
- phase  out  PHASE_BITS  current bus phase
- slot  out  $clog2(SLOTS) (min 1)  current slot index
- dev_slot  out  1  current slot is a device slot
- dev_grant  out  NUM_DEV  one-hot device grant for the current slot
- cpu_grant  out  1  CPU owns the memory for the current slot
- cpu_ack  out  1  acknowledge to the CPU (inverted externally to form DTACK)
- cycle_ready  out  1  one-clk pulse on the last phase of every slot

Behaviour:
- Reset: phase=0, slot=0, dev_grant=0, cpu_grant=0, cpu_ack=0, cycle_ready=0, internal CPU latch=0. Reset mid-slot aborts the slot; no ack is issued after reset.
- Counters: on clk_en, phase increments. On the last phase (all ones) it wraps to 0 and slot increments, with slot wrapping SLOTS-1 -> 0. No change when clk_en is low.
- dev_slot = DEV_SLOT_MAP[slot], combinational from the registered slot.
- Phase 0 (on the clk_en edge that enters phase 0): in a device slot, dev_grant is set to the lowest-index set bit of dev_req, or 0 if none. In a CPU slot, dev_grant=0. dev_grant holds for the whole slot.
- At LATCH_PHASE with clk_en, the CPU latch samples cpu_req. cpu_grant is set if the latch samples 1 AND either:
  - the slot is a CPU slot, or
  - the slot is a device slot with dev_grant==0 and ALLOW_BORROW=1.
- A cpu_req that rises after LATCH_PHASE is not served in that slot; it waits for the next eligible slot.
- cpu_ack is registered. It is set on the clk where cpu_grant=1, phase>=DONE_PHASE and cpu_req=1. It is cleared on the clk after cpu_req falls.
- cpu_ack never asserts without cpu_grant in the same slot.
- cpu_grant and dev_grant clear on the wrap to phase 0. cpu_grant is then re-evaluated at LATCH_PHASE.
- If cpu_req drops mid-slot: cpu_ack clears the next clk, but cpu_grant stays until the slot end so the memory access completes.
- If cpu_req is still high at the slot end and the access was acknowledged, it is not re-granted until cpu_req has been low for at least one clk_en, so one bus cycle yields one access.
- cycle_ready = clk_en && phase == all ones, registered to align with the phase output.
- Simultaneous device requests: only the highest priority is granted. Lower-priority requesters must hold dev_req; the block keeps no queue.
- Latency: from cpu_req sampled at LATCH_PHASE, cpu_ack rises (DONE_PHASE-LATCH_PHASE) clk_en periods later plus 1 clk.

Test Plan:
- Defaults, clk_en every 4th clk, no requests -> phase cycles 0..7, slot toggles 0,1; cycle_ready pulses once per 32 clk; all grants 0.
- cpu_req high before phase 2 in slot 1 -> cpu_grant=1 from phase 2; cpu_ack=1 at phase 4; drop cpu_req -> cpu_ack=0 the next clk; cpu_grant=0 at the next phase 0.
- dev_req=3'b110 at phase 0 of slot 0 -> dev_grant=3'b010 for 8 phases. A simultaneous cpu_req in the same slot is not granted; the CPU is served in slot 1.
- dev_req=0 in slot 0 with cpu_req held: ALLOW_BORROW=1 -> cpu_ack at phase 4 of slot 0; ALLOW_BORROW=0 -> cpu_ack at phase 4 of slot 1.
- cpu_req rises at phase 3 of slot 1 -> no grant in slot 1. With ALLOW_BORROW=1 and no device request, the access is served in slot 0 (ack at phase 4); otherwise it is served in the next slot 1.
- reset asserted at phase 5 while cpu_ack=1 -> next clk: phase=0, slot=0, cpu_ack=0, all grants 0. SLOTS=4, DEV_SLOT_MAP=4'b0101 -> device slots 0 and 2 only.
